// File: rtl/psram_pkg.sv
// Shared types, constants and helpers for the PSRAM transfer controller.
// Byte ordering helpers convert between bus order (byte0 first) and word order.
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_DATA,
        ST_DONE
    } phase_e;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int MAX_BYTES = 4;

    localparam logic [3:0] DOUTEN_SPI  = 4'b0001;
    localparam logic [3:0] DOUTEN_QUAD = 4'b1111;

    function automatic logic [2:0] eff_bytes(input logic [2:0] sz);
        return (sz == 3'd0 || sz > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : sz;
    endfunction

    // Places byte0 in the top byte so it leaves the shifter first.
    function automatic logic [31:0] wr_order(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // The first received byte sits highest among the n captured bytes.
    function automatic logic [31:0] rd_order(input logic [31:0] w, input logic [2:0] n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(n)) r[8*i +: 8] = w[8*(int'(n) - 1 - i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/psram_shifter.sv
// 32-bit load/shift register, MSB-first out, serial in at the LSB end.
// Steps by one bit in single-lane mode or by one nibble in quad mode.
module psram_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_shift,
    input  logic        i_quad,
    input  logic [3:0]  i_sin,
    output logic [31:0] o_word,
    output logic [3:0]  o_sout
);

    logic [31:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
        end else if (i_load) begin
            r_word <= i_load_val;
        end else if (i_shift) begin
            r_word <= i_quad ? {r_word[27:0], i_sin} : {r_word[30:0], i_sin[0]};
        end
    end

    assign o_word = r_word;
    assign o_sout = r_word[31:28];

endmodule

// File: rtl/psram_xfer_ctrl.sv
// Responder for the start/done PSRAM command interface: runs one descriptor
// on the serial PSRAM bus in SPI, QSPI or QPI mode and returns read data.
module psram_xfer_ctrl
    import psram_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [2:0]            size,
    input  logic                  rd_wr,
    input  logic [7:0]            cmd,
    input  logic [3:0]            wait_states,
    input  logic                  qspi,
    input  logic                  qpi,
    input  logic                  short_cmd,
    output logic                  done,
    output logic                  sck,
    output logic                  ce_n,
    input  logic [3:0]            din,
    output logic [3:0]            dout,
    output logic [3:0]            douten
);

    phase_e                r_state;
    phase_e                w_next_state;
    logic                  r_start_d;
    logic                  r_sck;
    logic [5:0]            r_bit_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_bytes;
    logic                  r_rd;
    logic [3:0]            r_ws;
    logic                  r_qpi;
    logic                  r_quad;
    logic [31:0]           r_data_o;

    logic                  w_start_rise;
    logic [5:0]            w_len;
    logic                  w_last;
    logic                  w_sck_next;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;
    logic                  w_load;
    logic [31:0]           w_load_val;
    logic                  w_shift;
    logic                  w_step_quad;
    logic [3:0]            w_sin;
    logic [31:0]           w_word;
    logic [3:0]            w_sout;

    assign w_start_rise = start & ~r_start_d;
    assign w_last       = (r_bit_cnt == w_len - 6'd1);
    assign w_step_quad  = (r_state == ST_CMD) ? r_qpi : r_quad;
    assign w_sin        = r_quad ? din : {3'b000, din[1]};

    always_comb begin
        w_len = '0;
        case (r_state)
            ST_CMD:  w_len = r_qpi  ? 6'(CMD_BITS / 4)  : 6'(CMD_BITS);
            ST_ADDR: w_len = r_quad ? 6'(ADDR_BITS / 4) : 6'(ADDR_BITS);
            ST_WAIT: w_len = {2'b00, r_ws};
            ST_DATA: w_len = r_quad ? {2'b00, r_bytes, 1'b0} : {r_bytes, 3'b000};
            default: w_len = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Every phase advances on the edge that ends an sck-high cycle; DATA keeps
    // one extra low cycle after its last period so ce_n rises two cycles later.
    always_comb begin
        w_next_state = r_state;
        w_sck_next   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_load    = 1'b1;
                    w_cnt_clr = 1'b1;
                    if (short_cmd) begin
                        w_next_state = ST_ADDR;
                        w_load_val   = {ADDR_BITS'(addr), 8'h00};
                    end else begin
                        w_next_state = ST_CMD;
                        w_load_val   = {cmd, 24'h000000};
                    end
                end
            end
            ST_CMD: begin
                w_sck_next = ~r_sck;
                if (r_sck) begin
                    if (w_last) begin
                        w_next_state = ST_ADDR;
                        w_load       = 1'b1;
                        w_load_val   = {ADDR_BITS'(r_addr), 8'h00};
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_shift   = 1'b1;
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                w_sck_next = ~r_sck;
                if (r_sck) begin
                    if (w_last) begin
                        w_next_state = (r_rd && r_ws != 4'd0) ? ST_WAIT : ST_DATA;
                        w_load       = 1'b1;
                        w_load_val   = r_rd ? 32'h0 : wr_order(r_wdata);
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_shift   = 1'b1;
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                w_sck_next = ~r_sck;
                if (r_sck) begin
                    if (w_last) begin
                        w_next_state = ST_DATA;
                        w_load       = 1'b1;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (r_bit_cnt == w_len) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_sck_next = ~r_sck;
                    if (r_sck) begin
                        w_shift   = 1'b1;
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
            r_sck     <= 1'b0;
            r_bit_cnt <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bytes   <= '0;
            r_rd      <= 1'b0;
            r_ws      <= '0;
            r_qpi     <= 1'b0;
            r_quad    <= 1'b0;
            r_data_o  <= '0;
        end else begin
            r_start_d <= start;
            r_sck     <= w_sck_next;
            if (w_cnt_clr)      r_bit_cnt <= '0;
            else if (w_cnt_inc) r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_state == ST_IDLE && w_start_rise) begin
                r_addr  <= addr;
                r_wdata <= 32'(data_i);
                r_bytes <= eff_bytes(size);
                r_rd    <= rd_wr;
                r_ws    <= wait_states;
                r_qpi   <= qpi;
                r_quad  <= qspi | qpi;
            end
            if (r_state == ST_DATA && w_next_state == ST_DONE && r_rd) begin
                r_data_o <= rd_order(w_word, r_bytes);
            end
        end
    end

    psram_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_shift    (w_shift),
        .i_quad     (w_step_quad),
        .i_sin      (w_sin),
        .o_word     (w_word),
        .o_sout     (w_sout)
    );

    always_comb begin
        douten = 4'b0000;
        case (r_state)
            ST_CMD:  douten = r_qpi  ? DOUTEN_QUAD : DOUTEN_SPI;
            ST_ADDR: douten = r_quad ? DOUTEN_QUAD : DOUTEN_SPI;
            ST_DATA: douten = r_rd ? 4'b0000 : (r_quad ? DOUTEN_QUAD : DOUTEN_SPI);
            default: douten = 4'b0000;
        endcase
    end

    always_comb begin
        dout = 4'b0000;
        if (douten == DOUTEN_QUAD)     dout = w_sout;
        else if (douten == DOUTEN_SPI) dout = {3'b000, w_sout[3]};
    end

    assign ce_n   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign done   = (r_state == ST_DONE);
    assign sck    = r_sck;
    assign data_o = DATA_WIDTH'(r_data_o);

endmodule

// File: tb/tb_psram_xfer_ctrl.sv
// Self-checking bench for psram_xfer_ctrl: table vectors, hand sequences for
// reset and start handling, and random descriptors against a bus-level model.
module tb_psram_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [2:0]  size;
    logic        rd_wr;
    logic [7:0]  cmd;
    logic [3:0]  wait_states;
    logic        qspi;
    logic        qpi;
    logic        short_cmd;
    logic        done;
    logic        sck;
    logic        ce_n;
    logic [3:0]  din;
    logic [3:0]  dout;
    logic [3:0]  douten;

    always #5 clk = ~clk;

    psram_xfer_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .addr        (addr),
        .data_i      (data_i),
        .data_o      (data_o),
        .size        (size),
        .rd_wr       (rd_wr),
        .cmd         (cmd),
        .wait_states (wait_states),
        .qspi        (qspi),
        .qpi         (qpi),
        .short_cmd   (short_cmd),
        .done        (done),
        .sck         (sck),
        .ce_n        (ce_n),
        .din         (din),
        .dout        (dout),
        .douten      (douten)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [31:0] dataI;
        logic [2:0]  size;
        logic        rdWr;
        logic [3:0]  ws;
        logic        qspi;
        logic        qpi;
        logic        shortCmd;
        logic [31:0] rdWord;
        int          expN;
        logic [31:0] expDataO;
    } vec_t;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [3:0]  expDout[$];
    logic [3:0]  expOe[$];
    logic [3:0]  dinSym[$];
    logic [31:0] lastDataO = 32'h0;
    logic [31:0] modelDataO;
    int          modelN;
    vec_t        vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic [7:0] c, input logic [23:0] a, input logic [31:0] di,
                                   input logic [2:0] sz, input logic rw, input logic [3:0] ws,
                                   input logic qs, input logic qp, input logic sc,
                                   input logic [31:0] rdw, input int n, input logic [31:0] edo);
        vec_t v;
        v.cmd = c; v.addr = a; v.dataI = di; v.size = sz; v.rdWr = rw; v.ws = ws;
        v.qspi = qs; v.qpi = qp; v.shortCmd = sc; v.rdWord = rdw; v.expN = n; v.expDataO = edo;
        return v;
    endfunction

    function automatic vec_t randomVec();
        return mkVec(8'($urandom), 24'($urandom), $urandom, 3'($urandom), 1'($urandom),
                     4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 0, 32'h0);
    endfunction

    task automatic applyStimulus(input vec_t d);
        cmd = d.cmd; addr = d.addr; data_i = d.dataI; size = d.size; rd_wr = d.rdWr;
        wait_states = d.ws; qspi = d.qspi; qpi = d.qpi; short_cmd = d.shortCmd;
    endtask

    task automatic pushSym(input logic [3:0] dv, input logic [3:0] oe, input logic [3:0] dn);
        expDout.push_back(dv);
        expOe.push_back(oe);
        dinSym.push_back(dn);
    endtask

    // Bus-level model: one queue entry per sck period with what the bench
    // expects on dout/douten and what the memory drives on din.
    task automatic buildModel(input vec_t d);
        bit          quad;
        int          nBytes;
        logic [7:0]  byteVal;
        logic [3:0]  sym;
        logic [31:0] mask;
        expDout.delete(); expOe.delete(); dinSym.delete();
        quad   = d.qspi | d.qpi;
        nBytes = (d.size == 3'd0 || d.size > 3'd4) ? 4 : int'(d.size);
        if (!d.shortCmd) begin
            if (d.qpi) for (int i = 1; i >= 0; i--) pushSym(d.cmd[4*i +: 4], 4'hF, 4'($urandom));
            else       for (int i = 7; i >= 0; i--) pushSym({3'b000, d.cmd[i]}, 4'h1, 4'($urandom));
        end
        if (quad) for (int i = 5; i >= 0; i--)  pushSym(d.addr[4*i +: 4], 4'hF, 4'($urandom));
        else      for (int i = 23; i >= 0; i--) pushSym({3'b000, d.addr[i]}, 4'h1, 4'($urandom));
        if (d.rdWr) for (int i = 0; i < int'(d.ws); i++) pushSym(4'h0, 4'h0, 4'($urandom));
        for (int b = 0; b < nBytes; b++) begin
            byteVal = d.rdWr ? d.rdWord[8*b +: 8] : d.dataI[8*b +: 8];
            if (quad) begin
                for (int h = 1; h >= 0; h--) begin
                    if (d.rdWr) pushSym(4'h0, 4'h0, byteVal[4*h +: 4]);
                    else        pushSym(byteVal[4*h +: 4], 4'hF, 4'($urandom));
                end
            end else begin
                for (int i = 7; i >= 0; i--) begin
                    if (d.rdWr) begin
                        sym = 4'($urandom);
                        sym[1] = byteVal[i];
                        pushSym(4'h0, 4'h0, sym);
                    end else begin
                        pushSym({3'b000, byteVal[i]}, 4'h1, 4'($urandom));
                    end
                end
            end
        end
        mask       = (nBytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nBytes)) - 32'h1);
        modelDataO = d.rdWr ? (d.rdWord & mask) : lastDataO;
        modelN     = expOe.size();
    endtask

    // Launches one transaction and follows it cycle by cycle to completion.
    task automatic runXfer(input vec_t d, input int expN, input logic [31:0] expDataO,
                           input bit holdStart, input bit glitch);
        int k;
        buildModel(d);
        start = 1'b0;
        applyStimulus(d);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 2 * expN + 2; c++) begin
            if (c == 1) begin
                applyStimulus(randomVec());
                if (!holdStart) start = 1'b0;
            end
            if (glitch && c == 7) start = 1'b0;
            if (glitch && c == 9) start = 1'b1;
            checkOutput($sformatf("ce_n c=%0d", c), 32'(ce_n), 32'(c == 2 * expN + 2));
            checkOutput($sformatf("sck c=%0d", c), 32'(sck), 32'((c % 2 == 0) && (c <= 2 * expN)));
            checkOutput($sformatf("done c=%0d", c), 32'(done), 32'(c == 2 * expN + 2));
            if ((c % 2 == 1) && (c < 2 * expN)) begin
                k = (c - 1) / 2;
                checkOutput($sformatf("douten period=%0d", k), 32'(douten), 32'(expOe[k]));
                if (expOe[k] != 4'h0)
                    checkOutput($sformatf("dout period=%0d", k), 32'(dout), 32'(expDout[k]));
                din = dinSym[k];
            end
            if (c == 2 * expN + 2) checkOutput("data_o at done", data_o, expDataO);
            @(posedge clk); #1;
        end
        checkOutput("ce_n after done", 32'(ce_n), 32'h1);
        checkOutput("done after done", 32'(done), 32'h0);
        lastDataO = expDataO;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        start = 1'b0;
        din   = 4'h0;
        applyStimulus(mkVec(8'h00, 24'h0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ce_n", 32'(ce_n), 32'h1);
        checkOutput("reset sck", 32'(sck), 32'h0);
        checkOutput("reset dout", 32'(dout), 32'h0);
        checkOutput("reset douten", 32'(douten), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset data_o", data_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs[0] = mkVec(8'h02, 24'h000010, 32'hA1B2C3D4, 3'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0,        64, 32'h0);
        vecs[1] = mkVec(8'hEB, 24'h123456, 32'h0,        3'd2, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 32'h00005AC3, 18, 32'h00005AC3);
        vecs[2] = mkVec(8'h38, 24'hABCDEF, 32'h0000007E, 3'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h0,         8, 32'h00005AC3);
        vecs[3] = mkVec(8'h03, 24'h000100, 32'h0,        3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 64, 32'hDEADBEEF);
        vecs[4] = mkVec(8'h0B, 24'h00FF00, 32'h0,        3'd3, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 32'h11223344, 58, 32'h00223344);
        vecs[5] = mkVec(8'h6B, 24'h3C3C3C, 32'h0,        3'd7, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 37, 32'hCAFEF00D);
        vecs[6] = mkVec(8'h32, 24'h765432, 32'h00009A5F, 3'd2, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 32'h0,        18, 32'hCAFEF00D);
        vecs[7] = mkVec(8'h38, 24'h0F1E2D, 32'h87654321, 3'd4, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 32'h0,        14, 32'hCAFEF00D);
        for (int i = 0; i < 8; i++) runXfer(vecs[i], vecs[i].expN, vecs[i].expDataO, 1'b0, 1'b0);

        // Reset in the middle of the address phase of a single-lane read.
        start = 1'b0;
        applyStimulus(mkVec(8'h03, 24'h0A0B0C, 32'h0, 3'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0));
        @(posedge clk); #1;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("ce_n in addr phase", 32'(ce_n), 32'h0);
        checkOutput("sck in addr phase", 32'(sck), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset ce_n", 32'(ce_n), 32'h1);
        checkOutput("mid reset sck", 32'(sck), 32'h0);
        checkOutput("mid reset douten", 32'(douten), 32'h0);
        checkOutput("mid reset done", 32'(done), 32'h0);
        checkOutput("mid reset data_o", data_o, 32'h0);
        lastDataO = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = mkVec(8'h03, 24'h0A0B0C, 32'h0, 3'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 32'h89ABCDEF, 64, 32'h89ABCDEF);
        runXfer(v, v.expN, v.expDataO, 1'b0, 1'b0);

        // Start held high through done, with a busy-time edge that must be ignored.
        v = mkVec(8'h38, 24'h112233, 32'h0000BEEF, 3'd2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 18, 32'h89ABCDEF);
        runXfer(v, v.expN, v.expDataO, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("no relaunch c=%0d", i), 32'(ce_n), 32'h1);
            @(posedge clk); #1;
        end
        v = mkVec(8'hEB, 24'h445566, 32'h0, 3'd1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 32'h1234565C, 13, 32'h0000005C);
        runXfer(v, v.expN, v.expDataO, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            v = randomVec();
            buildModel(v);
            runXfer(v, modelN, modelDataO, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
